i2c_master_regxfer: RTL
=======================

Name: i2c_master_regxfer

Overview:
- Synthesizable single-master I2C initiator that runs one complete register transaction per command.
- Write: START, {adr,W}, mem_adr, wdata, STOP.
- Read: START, {adr,W}, mem_adr, repeated START, {adr,R}, one data byte, master NACK, STOP.
- Drives open-drain SCL/SDA through enable pins. Its job is to exercise the I2C slave memory model and on-chip 7-bit-addressed, 8-bit-register slaves from the same bench and SoC fabric.

Parameters:
- PRESCALE, 4: clk cycles per SCL quarter-period (legal range 1..65535).
- CNT_W, 16: width of the quarter-period counter.

Ports:
- clk  in  1  system clock.
- nReset  in  1  synchronous active-low reset.
- start  in  1  command strobe, sampled only while busy=0.
- rw  in  1  1 = read, 0 = write; captured with start.
- slave_adr  in  7  target address; captured with start.
- mem_adr  in  8  register address; captured with start.
- wdata  in  8  write data; captured with start.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at transaction end.
- ack_err  out  1  slave NACK seen in the last transaction; valid with done, held until the next start.
- rdata  out  8  read byte; updated only on a successful read.
- scl_i  in  1  SCL pad input.
- scl_oen  out  1  0 = drive SCL low, 1 = release.
- sda_i  in  1  SDA pad input.
- sda_oen  out  1  0 = drive SDA low, 1 = release.

Behaviour:
- Reset (nReset=0 at a clk edge):
  - busy=0, done=0, ack_err=0, rdata=8'h00, scl_oen=1, sda_oen=1; FSM goes to IDLE.
  - This applies mid-transaction: both lines are released on the next edge and no STOP is generated.
- Timing unit is the quarter Q = PRESCALE clks. Each bit, START, RSTART and STOP takes 4 quarters, q0..q3.
- Data bit quarters:
  - q0: SCL low, SDA set to the bit.
  - q1: SCL released.
  - q2: SCL high; sda_i sampled on the last clk of q2.
  - q3: SCL high, then SCL driven low at the end of q3.
  - SDA changes only while SCL is low.
- Clock stretching: in q1, the quarter counter holds while scl_i=0. Counting resumes on the first clk with scl_i=1. There is no timeout.
- START:
  - q0–q1: both lines released.
  - q2: SDA low while SCL high.
  - q3: SCL low.
- RSTART:
  - q0: SDA released, SCL low.
  - q1: SCL released (stretch rule applies).
  - q2: SDA low.
  - q3: SCL low.
- STOP:
  - q0: SCL low, SDA low.
  - q1: SCL released (stretch rule applies).
  - q2: SDA held low.
  - q3: SDA released.
  - After q3: done=1 for one clk, busy=0.
- FSM states: IDLE, START, BYTE, ACK, RSTART, STOP, DONE.
  - Bytes go MSB first using a 3-bit down counter. ACK is the 9th bit.
  - In a master-transmit ACK, SDA is released and the sampled value 1 = NACK.
  - In a master-receive byte, SDA is released and sda_i is shifted in. The following ACK drives SDA released (NACK, single-byte read).
- Byte sequence:
  - Write: {slave_adr,0}, mem_adr, wdata.
  - Read: {slave_adr,0}, mem_adr, RSTART, {slave_adr,1}, read byte.
- NACK from the slave in any slave-ACK slot: go straight to STOP, ack_err=1, rdata unchanged.
- Start handshake:
  - start=1 with busy=0 captures all inputs; busy=1 on the next clk.
  - start while busy=1 is ignored.
  - start and done in the same cycle: the new command is accepted the cycle after done (busy must read 0).
- Latency from start-accept to done, with no stretching:
  - Write: (4+27·4+4)·PRESCALE clks = 116 quarters (464 clk at PRESCALE=4).
  - Read: (4+18·4+4+18·4+4) = 156 quarters (624 clk).
  - Each stretched clk adds exactly one clk.
- There is no arbitration. The block assumes it is the sole master. Its own released lines reading low outside q1 is not an error.

Test Plan:
- Write, slave at 7'h10, mem_adr=8'h03, wdata=8'hA5, PRESCALE=4 → slave mem[3]=A5; done at clk 464 after accept; ack_err=0; SDA never toggles while SCL is high except at START/STOP.
- Read back mem_adr=8'h03 → repeated START observed, rdata=8'hA5, master NACK on the 9th bit of the read byte, done at clk 624, ack_err=0.
- Wrong address 7'h22 with no responder → NACK after the first byte; STOP follows at once; ack_err=1; rdata keeps its previous value; done after (4+9·4+4)·4 = 176 clk.
- Slave holds SCL low 37 clks in q1 of the 3rd bit of the write → done delayed by exactly 37 clks; written data still correct.
- Assert nReset for one clk mid-way through the mem_adr byte → scl_oen=sda_oen=1, busy=0 next clk; a new write to mem_adr=8'h01 with wdata=8'h5A then completes normally.
- Pulse start during busy, and again on the done cycle → first is ignored, second is ignored; a start held one clk later is accepted, with busy rising the following clk.

Source files
------------

// File: rtl/i2c_master_regxfer.sv
// Single-master I2C initiator: one register write (adr,mem,data) or
// single-byte register read (adr,mem,RSTART,adr|R,data) per start strobe.
module i2c_master_regxfer #(
   parameter int unsigned PRESCALE = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic       clk,
   input  logic       nReset,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] slave_adr,
   input  logic [7:0] mem_adr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] rdata,
   input  logic       scl_i,
   output logic       scl_oen,
   input  logic       sda_i,
   output logic       sda_oen
);

   localparam logic [CNT_W-1:0] QEND = CNT_W'(PRESCALE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BYTE, S_ACK, S_RSTART, S_STOP, S_DONE
   } state_t;

   state_t           r_state;
   logic [1:0]       r_q;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [1:0]       r_idx;
   logic [7:0]       r_shift;
   logic             r_rw;
   logic [6:0]       r_adr;
   logic [7:0]       r_mem;
   logic [7:0]       r_wdata;
   logic             r_nack;
   logic             r_busy;
   logic             r_done;
   logic             r_ack_err;
   logic [7:0]       r_rdata;
   logic             r_scl;
   logic             r_sda;

   logic             w_active;
   logic             w_hold;
   logic             w_qend;
   logic             w_rx;
   logic [7:0]       w_next;

   // q1 of every symbol waits for the slave to release SCL (clock stretching)
   assign w_active = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_hold   = w_active && (r_q == 2'd1) && !scl_i;
   assign w_qend   = w_active && !w_hold && (r_cnt == QEND);
   assign w_rx     = r_rw && (r_idx == 2'd3);
   assign w_next   = (r_idx == 2'd0) ? r_mem :
                     (r_idx == 2'd1) ? r_wdata : 8'hFF;

   // Line levels are set on the edge that enters each quarter
   always_ff @(posedge clk) begin
      if (!nReset) begin
         r_state   <= S_IDLE;
         r_q       <= 2'd0;
         r_cnt     <= '0;
         r_bit     <= 3'd0;
         r_idx     <= 2'd0;
         r_shift   <= 8'h00;
         r_rw      <= 1'b0;
         r_adr     <= 7'h00;
         r_mem     <= 8'h00;
         r_wdata   <= 8'h00;
         r_nack    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ack_err <= 1'b0;
         r_rdata   <= 8'h00;
         r_scl     <= 1'b1;
         r_sda     <= 1'b1;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (start) begin
               r_state   <= S_START;
               r_rw      <= rw;
               r_adr     <= slave_adr;
               r_mem     <= mem_adr;
               r_wdata   <= wdata;
               r_shift   <= {slave_adr, 1'b0};
               r_idx     <= 2'd0;
               r_q       <= 2'd0;
               r_cnt     <= '0;
               r_busy    <= 1'b1;
               r_ack_err <= 1'b0;
            end
         end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
         end else if (!w_hold) begin
            if (!w_qend) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end else begin
               r_cnt <= '0;
               r_q   <= r_q + 2'd1;
               case (r_state)
                  S_START: begin
                     case (r_q)
                        2'd1: r_sda <= 1'b0;
                        2'd2: r_scl <= 1'b0;
                        2'd3: begin
                           r_state <= S_BYTE;
                           r_bit   <= 3'd7;
                           r_sda   <= r_shift[7];
                        end
                        default: ;
                     endcase
                  end
                  S_BYTE: begin
                     case (r_q)
                        2'd0: r_scl <= 1'b1;
                        2'd2: r_shift <= {r_shift[6:0], sda_i};
                        2'd3: begin
                           r_scl <= 1'b0;
                           if (r_bit == 3'd0) begin
                              r_state <= S_ACK;
                              r_sda   <= 1'b1;
                           end else begin
                              r_bit <= r_bit - 3'd1;
                              r_sda <= r_shift[7];
                           end
                        end
                        default: ;
                     endcase
                  end
                  S_ACK: begin
                     case (r_q)
                        2'd0: r_scl <= 1'b1;
                        2'd2: r_nack <= sda_i;
                        2'd3: begin
                           r_scl <= 1'b0;
                           // master NACKs the single read byte; slave NACK aborts
                           if (w_rx) begin
                              r_state <= S_STOP;
                              r_sda   <= 1'b0;
                              r_rdata <= r_shift;
                           end else if (r_nack) begin
                              r_state   <= S_STOP;
                              r_sda     <= 1'b0;
                              r_ack_err <= 1'b1;
                           end else if (!r_rw && (r_idx == 2'd2)) begin
                              r_state <= S_STOP;
                              r_sda   <= 1'b0;
                           end else if (r_rw && (r_idx == 2'd1)) begin
                              r_state <= S_RSTART;
                              r_sda   <= 1'b1;
                           end else begin
                              r_state <= S_BYTE;
                              r_idx   <= r_idx + 2'd1;
                              r_bit   <= 3'd7;
                              r_shift <= w_next;
                              r_sda   <= w_next[7];
                           end
                        end
                        default: ;
                     endcase
                  end
                  S_RSTART: begin
                     case (r_q)
                        2'd0: r_scl <= 1'b1;
                        2'd1: r_sda <= 1'b0;
                        2'd2: r_scl <= 1'b0;
                        default: begin
                           r_state <= S_BYTE;
                           r_idx   <= 2'd2;
                           r_bit   <= 3'd7;
                           r_shift <= {r_adr, 1'b1};
                           r_sda   <= r_adr[6];
                        end
                     endcase
                  end
                  S_STOP: begin
                     case (r_q)
                        2'd0: r_scl <= 1'b1;
                        2'd2: r_sda <= 1'b1;
                        2'd3: begin
                           r_state <= S_DONE;
                           r_done  <= 1'b1;
                           r_busy  <= 1'b0;
                        end
                        default: ;
                     endcase
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign ack_err = r_ack_err;
   assign rdata   = r_rdata;
   assign scl_oen = r_scl;
   assign sda_oen = r_sda;

endmodule
